// File: rtl/decoder_tx_encoder.sv
// decoder_tx_encoder: writes ASCII characters into the image SRAM as 3x3
// pixel tiles, one 4-bit word per pixel row at col, col+ROW_STRIDE and
// col+2*ROW_STRIDE, in the bit layout the 3-row image decoder reads back.
module decoder_tx_encoder #(
  parameter int SRAM_DATA_WIDTH = 4,
  parameter int SRAM_ADDR_WIDTH = 7,
  parameter int DATA_WIDTH      = 8,
  parameter int ROW_STRIDE      = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      width,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_char,
  input  logic                       in_mode,
  output logic                       SRAM_wen,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_addr,
  output logic [SRAM_DATA_WIDTH-1:0] SRAM_wdata,
  output logic                       done
);

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, DONE} state_t;

  state_t                     state, state_nx;
  logic [DATA_WIDTH-1:0]      col, col_nx;
  logic [DATA_WIDTH-1:0]      ncol;
  logic [DATA_WIDTH-1:0]      char_q;
  logic                       mode_q;
  logic                       last;
  logic                       accept;
  logic [SRAM_ADDR_WIDTH-1:0] col_addr;

  // Pixel row word {b2,b1,b0}; row 0 bit 0 carries the layout flag.
  function automatic logic [2:0] row_word(input logic [7:0] c, input logic m,
                                          input logic [1:0] r);
    logic [2:0] w;
    case ({m, r})
      3'b000:  w = {c[6], c[7], 1'b0};
      3'b001:  w = {c[3], c[4], c[5]};
      3'b010:  w = {c[0], c[1], c[2]};
      3'b100:  w = {c[2], c[5], 1'b1};
      3'b101:  w = {c[1], c[4], c[7]};
      3'b110:  w = {c[0], c[3], c[6]};
      default: w = 3'b000;
    endcase
    return w;
  endfunction

  assign ncol     = DATA_WIDTH'(width / 3);
  assign last     = (col == ncol - 1'b1);
  assign col_addr = SRAM_ADDR_WIDTH'(col);

  // State, column and latched character registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      col    <= '0;
      char_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
      if (accept) begin
        char_q <= in_char;
        mode_q <= in_mode;
      end
    end
  end

  // Handshake and next-state logic.
  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    state_nx = state;
    col_nx   = col;
    case (state)
      IDLE: in_ready = (ncol != '0);
      WR2:  in_ready = !last;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state)
      IDLE: if (accept) state_nx = WR0;
      WR0:  state_nx = WR1;
      WR1:  state_nx = WR2;
      WR2: begin
        if (last) begin
          state_nx = DONE;
        end else begin
          col_nx   = col + 1'b1;
          state_nx = accept ? WR0 : IDLE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        col_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // SRAM write port and done pulse, decoded from the current state.
  always_comb begin
    SRAM_wen   = 1'b0;
    SRAM_addr  = '0;
    SRAM_wdata = '0;
    done       = 1'b0;
    case (state)
      WR0: begin
        SRAM_wen        = 1'b1;
        SRAM_addr       = col_addr;
        SRAM_wdata[2:0] = row_word(char_q[7:0], mode_q, 2'd0);
      end
      WR1: begin
        SRAM_wen        = 1'b1;
        SRAM_addr       = col_addr + SRAM_ADDR_WIDTH'(ROW_STRIDE);
        SRAM_wdata[2:0] = row_word(char_q[7:0], mode_q, 2'd1);
      end
      WR2: begin
        SRAM_wen        = 1'b1;
        SRAM_addr       = col_addr + SRAM_ADDR_WIDTH'(2 * ROW_STRIDE);
        SRAM_wdata[2:0] = row_word(char_q[7:0], mode_q, 2'd2);
      end
      DONE: done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_decoder_tx_encoder.sv
// Bench for decoder_tx_encoder: a schedule-based model of expected outputs
// checked every cycle, plus directed vectors with hand-computed writes.
module tb_decoder_tx_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] width;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       in_mode;
  logic       SRAM_wen;
  logic [6:0] SRAM_addr;
  logic [3:0] SRAM_wdata;
  logic       done;

  int checks   = 0;
  int failures = 0;

  decoder_tx_encoder #(
    .SRAM_DATA_WIDTH(4),
    .SRAM_ADDR_WIDTH(7),
    .DATA_WIDTH(8),
    .ROW_STRIDE(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .width(width),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_char(in_char),
    .in_mode(in_mode),
    .SRAM_wen(SRAM_wen),
    .SRAM_addr(SRAM_addr),
    .SRAM_wdata(SRAM_wdata),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: queue of expected outputs, head = current cycle, empty = idle.
  typedef struct {
    logic       wen;
    logic [6:0] addr;
    logic [3:0] data;
    logic       done;
  } out_t;

  out_t sched[$];
  int   idx      = 0;
  bit   model_on = 0;

  // Tile pixel (row r, column j): row-major numbers pixels 3*(2-r)+j,
  // column-major numbers them 3*j+2-r; pixel 8 is the layout flag.
  function automatic logic [3:0] exp_word(input logic [7:0] c, input logic m, input int r);
    logic [3:0] w;
    int k;
    w = 4'h0;
    for (int j = 0; j < 3; j++) begin
      k = m ? (3 * j + 2 - r) : (3 * (2 - r) + j);
      w[2 - j] = (k == 8) ? m : c[k];
    end
    return w;
  endfunction

  function automatic bit model_ready();
    int n;
    n = int'(width) / 3;
    return (n != 0) && (sched.size() == 0 || (sched.size() == 1 && sched[0].wen));
  endfunction

  always @(posedge clk) begin : model_upd
    bit acc;
    if (rst) begin
      sched.delete();
      idx      = 0;
      model_on = 1;
    end else if (model_on) begin
      acc = in_valid && model_ready();
      if (sched.size() > 0) void'(sched.pop_front());
      if (acc) begin
        for (int r = 0; r < 3; r++)
          sched.push_back('{wen: 1'b1, addr: 7'(idx + 40 * r),
                            data: exp_word(in_char, in_mode, r), done: 1'b0});
        if (idx == int'(width) / 3 - 1) begin
          sched.push_back('{wen: 1'b0, addr: 7'd0, data: 4'd0, done: 1'b1});
          idx = 0;
        end else begin
          idx++;
        end
      end
    end
  end

  always @(negedge clk) begin : model_cmp
    out_t e;
    if (model_on) begin
      if (sched.size() > 0) e = sched[0];
      else e = '{wen: 1'b0, addr: 7'd0, data: 4'd0, done: 1'b0};
      chk("m_ready", in_ready,   model_ready());
      chk("m_wen",   SRAM_wen,   e.wen);
      chk("m_addr",  SRAM_addr,  e.addr);
      chk("m_wdata", SRAM_wdata, e.data);
      chk("m_done",  done,       e.done);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic expect_wr(input string name, input int a, input int d, input bit rdy);
    @(negedge clk);
    chk({name, "_wen"},   SRAM_wen,   1);
    chk({name, "_addr"},  SRAM_addr,  a);
    chk({name, "_data"},  SRAM_wdata, d);
    chk({name, "_ready"}, in_ready,   rdy);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; in_mode = 1'b0; width = 8'd120;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_wen",   SRAM_wen, 0);
    chk("rst_addr",  SRAM_addr, 0);
    chk("rst_data",  SRAM_wdata, 0);
    chk("rst_done",  done, 0);

    // row-major 'A', inputs disturbed after accept
    in_valid = 1'b1; in_char = 8'h41; in_mode = 1'b0;
    cycle();
    in_valid = 1'b0; in_char = 8'hFF; in_mode = 1'b1;
    expect_wr("rowA0", 0, 4'h4, 0);
    expect_wr("rowA1", 40, 4'h0, 0);
    expect_wr("rowA2", 80, 4'h4, 1);
    @(negedge clk);
    chk("rowA_idle_ready", in_ready, 1);
    chk("rowA_idle_wen", SRAM_wen, 0);

    // column-major 'A' lands in column 1
    in_valid = 1'b1; in_char = 8'h41; in_mode = 1'b1;
    cycle();
    in_valid = 1'b0;
    expect_wr("colA0", 1, 4'h1, 0);
    expect_wr("colA1", 41, 4'h0, 0);
    expect_wr("colA2", 81, 4'h5, 1);

    // back-to-back 'Z','A'
    do_reset();
    in_valid = 1'b1; in_char = 8'h5A; in_mode = 1'b0;
    cycle();
    in_char = 8'h41;
    expect_wr("b2bZ0", 0, 4, 0);
    expect_wr("b2bZ1", 40, 6, 0);
    expect_wr("b2bZ2", 80, 2, 1);
    in_valid = 1'b0;
    expect_wr("b2bA0", 1, 4, 0);
    expect_wr("b2bA1", 41, 0, 0);
    expect_wr("b2bA2", 81, 4, 1);

    // full band, width 9
    width = 8'd9;
    do_reset();
    in_valid = 1'b1; in_char = 8'h30; in_mode = 1'b0;
    cycle();
    in_char = 8'h31;
    expect_wr("band00", 0, 0, 0);
    expect_wr("band01", 40, 3, 0);
    expect_wr("band02", 80, 0, 1);
    in_char = 8'h32;
    expect_wr("band10", 1, 0, 0);
    expect_wr("band11", 41, 3, 0);
    expect_wr("band12", 81, 4, 1);
    in_valid = 1'b0;
    expect_wr("band20", 2, 0, 0);
    expect_wr("band21", 42, 3, 0);
    expect_wr("band22", 82, 2, 0);
    @(negedge clk);
    chk("band_done", done, 1);
    chk("band_done_wen", SRAM_wen, 0);
    chk("band_done_ready", in_ready, 0);
    cycle();
    @(negedge clk);
    chk("band_after_done", done, 0);
    chk("band_after_ready", in_ready, 1);
    in_valid = 1'b1; in_char = 8'h41; in_mode = 1'b0;
    cycle();
    in_valid = 1'b0;
    expect_wr("band_next0", 0, 4, 0);
    expect_wr("band_next1", 40, 0, 0);
    expect_wr("band_next2", 80, 4, 1);

    // degenerate width
    width = 8'd2;
    do_reset();
    in_valid = 1'b1; in_char = 8'h41;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("degen_ready", in_ready, 0);
      chk("degen_wen", SRAM_wen, 0);
      chk("degen_done", done, 0);
      cycle();
    end
    in_valid = 1'b0;

    // reset during WR1 of the second character
    width = 8'd120;
    do_reset();
    in_valid = 1'b1; in_char = 8'h41; in_mode = 1'b0;
    cycle();
    in_char = 8'h5A;
    expect_wr("mrA0", 0, 4, 0);
    expect_wr("mrA1", 40, 0, 0);
    expect_wr("mrA2", 80, 4, 1);
    in_valid = 1'b0;
    expect_wr("mrZ0", 1, 4, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_wen", SRAM_wen, 0);
    chk("mr_done", done, 0);
    chk("mr_ready", in_ready, 1);
    in_valid = 1'b1; in_char = 8'h41;
    cycle();
    in_valid = 1'b0;
    expect_wr("mr_next0", 0, 4, 0);
    expect_wr("mr_next1", 40, 0, 0);
    expect_wr("mr_next2", 80, 4, 1);
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
